// File: rtl/score_bcd_counter_pkg.sv
// Shared game package for the score keeper and the HUD top level.
// Holds the BCD digit width, the display blank code, the nine constant
// and a helper that blanks leading zeros of a packed BCD vector.
package score_bcd_counter_pkg;

  localparam int               BCD_W      = 4;
  localparam logic [BCD_W-1:0] BLANK_CODE = 4'hF;
  localparam logic [BCD_W-1:0] DIGIT_NINE = 4'd9;

  // Widest vector the helper handles; callers zero-extend into it and
  // truncate the result back to their own width.
  localparam int MAX_DIGITS = 8;
  localparam int MAX_VEC_W  = BCD_W * MAX_DIGITS;

  // Replace every leading zero digit above the LSD with blank_code.
  // Only the lowest n_digits digits are considered; the LSD always shows.
  function automatic logic [MAX_VEC_W-1:0] bcd_blank(
    input logic [MAX_VEC_W-1:0] vec,
    input int                   n_digits,
    input logic [BCD_W-1:0]     blank_code
  );
    logic [MAX_VEC_W-1:0] res;
    logic                 leading;
    res     = vec;
    leading = 1'b1;
    for (int k = MAX_DIGITS - 1; k >= 1; k--) begin
      if (k < n_digits) begin
        if (leading && (vec[k*BCD_W +: BCD_W] == '0)) begin
          res[k*BCD_W +: BCD_W] = blank_code;
        end else begin
          leading = 1'b0;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/score_bcd_counter_digit_cell.sv
// One BCD digit of the live score.
// Ports:
//   iClk, iRstN : clock, asynchronous active-low reset
//   iClear      : synchronous clear of the digit (wins over stepping)
//   iInc        : increment enable for the whole counter this cycle
//   iCarry      : all lower digits are nine (constant 1 for the LSD)
//   oCarry      : this digit and all lower digits are nine
//   oDigit      : current digit value, always 0..9
module bcd_digit_cell
  import score_bcd_counter_pkg::*;
(
  input  logic             iClk,
  input  logic             iRstN,
  input  logic             iClear,
  input  logic             iInc,
  input  logic             iCarry,
  output logic             oCarry,
  output logic [BCD_W-1:0] oDigit
);

  logic [BCD_W-1:0] digit_q;
  logic [BCD_W-1:0] digit_d;
  logic             is_nine;

  assign is_nine = (digit_q == DIGIT_NINE);

  // The carry chain doubles as an "all lower digits are nine" probe, so the
  // MSD carry-out is the saturation flag and a digit steps only when every
  // digit below it is about to wrap.
  assign oCarry = iCarry & is_nine;
  assign oDigit = digit_q;

  always_comb begin
    digit_d = digit_q;
    if (iClear) begin
      digit_d = '0;
    end else if (iInc && iCarry) begin
      digit_d = is_nine ? '0 : digit_q + BCD_W'(1);
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

endmodule

// File: rtl/score_bcd_counter.sv
// Game score keeper feeding the seven-segment digit renderers.
// Counts rising edges of iScoreInc in packed BCD with saturation at all
// nines, tracks a session high score, and presents frame-stable,
// leading-zero-blanked digit codes that only change on iFrameStart.
// Ports:
//   iClk, iRstN  : clock, asynchronous active-low reset
//   iScoreInc    : score event level (rising edge counts once)
//   iClear       : synchronous new-game clear of the live score
//   iFrameStart  : one-cycle pulse at the start of vertical blanking
//   oDigits      : displayed live score, LSD in [3:0], blanked
//   oHighDigits  : displayed high score, same format
//   oNewHigh     : live score has beaten the high score since last clear
//   oSaturated   : live score is all nines (one cycle latency)
module score_bcd_counter #(
  parameter int         N_DIGITS   = 3,
  parameter logic [3:0] BLANK_CODE = 4'hF
) (
  input  logic                  iClk,
  input  logic                  iRstN,
  input  logic                  iScoreInc,
  input  logic                  iClear,
  input  logic                  iFrameStart,
  output logic [4*N_DIGITS-1:0] oDigits,
  output logic [4*N_DIGITS-1:0] oHighDigits,
  output logic                  oNewHigh,
  output logic                  oSaturated
);

  import score_bcd_counter_pkg::*;

  localparam int               DIG_W    = BCD_W * N_DIGITS;
  localparam logic [DIG_W-1:0] DISP_RST = DIG_W'(bcd_blank('0, N_DIGITS, BLANK_CODE));

  logic             inc_prev_q, inc_prev_d;
  logic [DIG_W-1:0] high_q, high_d;
  logic             new_high_q, new_high_d;
  logic             sat_q, sat_d;
  logic [DIG_W-1:0] disp_q, disp_d;
  logic [DIG_W-1:0] disp_high_q, disp_high_d;

  logic                inc_pulse;
  logic                inc_en;
  logic                all_nines;
  logic [N_DIGITS:0]   lower_nines;
  logic [DIG_W-1:0]    live;
  logic [N_DIGITS-1:0] dig_gt;
  logic [N_DIGITS-1:0] dig_eq;
  logic                live_gt_high;

  // A zero previous sample means a level held high out of reset counts once.
  assign inc_pulse = iScoreInc & ~inc_prev_q;
  assign inc_en    = inc_pulse & ~all_nines;

  assign lower_nines[0] = 1'b1;
  assign all_nines      = lower_nines[N_DIGITS];

  for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
    bcd_digit_cell u_cell (
      .iClk   (iClk),
      .iRstN  (iRstN),
      .iClear (iClear),
      .iInc   (inc_en),
      .iCarry (lower_nines[k]),
      .oCarry (lower_nines[k+1]),
      .oDigit (live[k*BCD_W +: BCD_W])
    );

    assign dig_gt[k] = live[k*BCD_W +: BCD_W] >  high_q[k*BCD_W +: BCD_W];
    assign dig_eq[k] = live[k*BCD_W +: BCD_W] == high_q[k*BCD_W +: BCD_W];
  end

  // MSD-first priority chain: the first unequal digit decides the compare.
  always_comb begin
    logic decided;
    live_gt_high = 1'b0;
    decided      = 1'b0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      if (!decided && !dig_eq[k]) begin
        live_gt_high = dig_gt[k];
        decided      = 1'b1;
      end
    end
  end

  always_comb begin
    inc_prev_d  = iScoreInc;
    high_d      = high_q;
    new_high_d  = new_high_q;
    sat_d       = all_nines;
    disp_d      = disp_q;
    disp_high_d = disp_high_q;

    if (live_gt_high) begin
      high_d     = live;
      new_high_d = 1'b1;
    end
    if (iClear) begin
      new_high_d = 1'b0;
    end

    // Latch the current registers, so an increment on the same edge shows
    // up only at the following frame.
    if (iFrameStart) begin
      disp_d      = DIG_W'(bcd_blank(MAX_VEC_W'(live),   N_DIGITS, BLANK_CODE));
      disp_high_d = DIG_W'(bcd_blank(MAX_VEC_W'(high_q), N_DIGITS, BLANK_CODE));
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      inc_prev_q  <= 1'b0;
      high_q      <= '0;
      new_high_q  <= 1'b0;
      sat_q       <= 1'b0;
      disp_q      <= DISP_RST;
      disp_high_q <= DISP_RST;
    end else begin
      inc_prev_q  <= inc_prev_d;
      high_q      <= high_d;
      new_high_q  <= new_high_d;
      sat_q       <= sat_d;
      disp_q      <= disp_d;
      disp_high_q <= disp_high_d;
    end
  end

  assign oDigits     = disp_q;
  assign oHighDigits = disp_high_q;
  assign oNewHigh    = new_high_q;
  assign oSaturated  = sat_q;

endmodule

// File: tb/tb_score_bcd_counter.sv
module tb_score_bcd_counter;

  logic        iClk = 1'b0;
  logic        iRstN;
  logic        iScoreInc;
  logic        iClear;
  logic        iFrameStart;
  logic [11:0] oDigits;
  logic [11:0] oHighDigits;
  logic        oNewHigh;
  logic        oSaturated;

  int n_vec = 0;
  int n_err = 0;

  score_bcd_counter #(
    .N_DIGITS   (3),
    .BLANK_CODE (4'hF)
  ) dut (
    .iClk        (iClk),
    .iRstN       (iRstN),
    .iScoreInc   (iScoreInc),
    .iClear      (iClear),
    .iFrameStart (iFrameStart),
    .oDigits     (oDigits),
    .oHighDigits (oHighDigits),
    .oNewHigh    (oNewHigh),
    .oSaturated  (oSaturated)
  );

  always #5 iClk = ~iClk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      iScoreInc = 1'b1;
      step();
      iScoreInc = 1'b0;
      step();
    end
  endtask

  task automatic frame();
    iFrameStart = 1'b1;
    step();
    iFrameStart = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    iRstN       = 1'b0;
    iScoreInc   = 1'b0;
    iClear      = 1'b0;
    iFrameStart = 1'b0;
    step();
    step();
    check("rst_digits",  32'(oDigits),     32'hFF0);
    check("rst_high",    32'(oHighDigits), 32'hFF0);
    check("rst_newhigh", 32'(oNewHigh),    32'h0);
    check("rst_sat",     32'(oSaturated),  32'h0);
    iRstN = 1'b1;
    step();
    frame();
    check("frame0_digits",  32'(oDigits),     32'hFF0);
    check("frame0_high",    32'(oHighDigits), 32'hFF0);
    check("frame0_newhigh", 32'(oNewHigh),    32'h0);
    check("frame0_sat",     32'(oSaturated),  32'h0);

    // 12 pulses
    pulses(12);
    check("no_frame_hold", 32'(oDigits), 32'hFF0);
    frame();
    check("s12_digits",  32'(oDigits),     32'hF12);
    check("s12_high",    32'(oHighDigits), 32'hF12);
    check("s12_newhigh", 32'(oNewHigh),    32'h1);

    // held high 50 cycles counts once
    iScoreInc = 1'b1;
    repeat (50) step();
    iScoreInc = 1'b0;
    step();
    frame();
    check("held_digits", 32'(oDigits), 32'hF13);

    // pulse coincident with clear is dropped
    iScoreInc = 1'b1;
    iClear    = 1'b1;
    step();
    iScoreInc = 1'b0;
    iClear    = 1'b0;
    step();
    frame();
    check("clr_digits",  32'(oDigits),     32'hFF0);
    check("clr_high",    32'(oHighDigits), 32'hF13);
    check("clr_newhigh", 32'(oNewHigh),    32'h0);

    // 099 then 100
    pulses(99);
    frame();
    check("s99_digits", 32'(oDigits),     32'hF99);
    check("s99_high",   32'(oHighDigits), 32'hF99);
    pulses(1);
    frame();
    check("s100_digits",  32'(oDigits),     32'h100);
    check("s100_high",    32'(oHighDigits), 32'h100);
    check("s100_newhigh", 32'(oNewHigh),    32'h1);
    check("s100_sat",     32'(oSaturated),  32'h0);

    // saturation
    pulses(1005);
    frame();
    check("sat_digits", 32'(oDigits),     32'h999);
    check("sat_high",   32'(oHighDigits), 32'h999);
    check("sat_flag",   32'(oSaturated),  32'h1);
    pulses(3);
    frame();
    check("sat_hold_digits", 32'(oDigits),    32'h999);
    check("sat_hold_flag",   32'(oSaturated), 32'h1);

    // asynchronous reset, checked before any clock edge
    #2;
    iRstN = 1'b0;
    #1;
    check("arst_digits", 32'(oDigits),     32'hFF0);
    check("arst_high",   32'(oHighDigits), 32'hFF0);
    check("arst_sat",    32'(oSaturated),  32'h0);
    step();
    iRstN = 1'b1;
    step();

    // score 37, clear, 20 pulses
    pulses(37);
    check("s37_newhigh", 32'(oNewHigh), 32'h1);
    iClear = 1'b1;
    step();
    iClear = 1'b0;
    pulses(20);
    frame();
    check("s20_digits",  32'(oDigits),     32'hF20);
    check("s20_high",    32'(oHighDigits), 32'hF37);
    check("s20_newhigh", 32'(oNewHigh),    32'h0);

    // live 38 overtakes the held 37 one cycle after the increment
    pulses(17);
    check("s37b_newhigh", 32'(oNewHigh), 32'h0);
    iScoreInc = 1'b1;
    step();
    check("s38_lag_newhigh", 32'(oNewHigh), 32'h0);
    iScoreInc = 1'b0;
    step();
    check("s38_newhigh",  32'(oNewHigh), 32'h1);
    check("s38_nofr_dig", 32'(oDigits),  32'hF20);
    frame();
    check("s38_digits", 32'(oDigits),     32'hF38);
    check("s38_high",   32'(oHighDigits), 32'hF38);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
